// File: rtl/riscv_ctrl_pkg.sv
// Shared encodings for the multi-cycle control unit: opcodes, FSM states,
// instruction classes and the datapath select encodings.
package riscv_ctrl_pkg;

  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_JALR = 7'b1100111;
  localparam logic [6:0] OP_HALT = 7'b0000001;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALTED,
    S_TRAPPED
  } state_t;

  typedef enum logic [3:0] {
    CLS_NONE,
    CLS_R,
    CLS_LW,
    CLS_SW,
    CLS_BR,
    CLS_I,
    CLS_LUI,
    CLS_JAL,
    CLS_JALR,
    CLS_HALT
  } iclass_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_LUI   = 2'b11;

  localparam logic [1:0] PCSRC_PLUS4 = 2'b00;
  localparam logic [1:0] PCSRC_IMM   = 2'b01;
  localparam logic [1:0] PCSRC_ALU   = 2'b10;

  localparam logic [1:0] WB_ALU = 2'b00;
  localparam logic [1:0] WB_MEM = 2'b01;
  localparam logic [1:0] WB_PC4 = 2'b10;

  localparam logic [1:0] TC_NONE    = 2'b00;
  localparam logic [1:0] TC_ILLEGAL = 2'b01;
  localparam logic [1:0] TC_IMEM    = 2'b10;
  localparam logic [1:0] TC_DMEM    = 2'b11;

endpackage

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multi-cycle controller (master) and the
// datapath/memories (slave).
interface multicycle_controller_if #(
  parameter int RETIRE_W = 32
);
  logic [6:0]          Opcode;
  logic                BranchTaken;
  logic                imem_ready;
  logic                dmem_ready;
  logic                imem_req;
  logic                IRWrite;
  logic                PCWrite;
  logic [1:0]          PCSrc;
  logic                ALUSrc;
  logic [1:0]          ALUOp;
  logic                MemRead;
  logic                MemWrite;
  logic [1:0]          WBSel;
  logic                RegWrite;
  logic                Halt;
  logic                Trap;
  logic [1:0]          TrapCause;
  logic [RETIRE_W-1:0] retired;

  modport master (
    input  Opcode, BranchTaken, imem_ready, dmem_ready,
    output imem_req, IRWrite, PCWrite, PCSrc, ALUSrc, ALUOp,
           MemRead, MemWrite, WBSel, RegWrite, Halt, Trap, TrapCause, retired
  );

  modport slave (
    output Opcode, BranchTaken, imem_ready, dmem_ready,
    input  imem_req, IRWrite, PCWrite, PCSrc, ALUSrc, ALUOp,
           MemRead, MemWrite, WBSel, RegWrite, Halt, Trap, TrapCause, retired
  );
endinterface

// File: rtl/ctrl_opcode_decode.sv
// Combinational opcode-to-class mapping; anything unrecognised is illegal.
module ctrl_opcode_decode
  import riscv_ctrl_pkg::*;
(
  input  logic [6:0] i_opcode,
  output iclass_t    o_class,
  output logic       o_illegal
);

  // Map the raw opcode onto an instruction class.
  always_comb begin
    o_class   = CLS_NONE;
    o_illegal = 1'b0;
    case (i_opcode)
      OP_R:    o_class = CLS_R;
      OP_LW:   o_class = CLS_LW;
      OP_SW:   o_class = CLS_SW;
      OP_BR:   o_class = CLS_BR;
      OP_I:    o_class = CLS_I;
      OP_LUI:  o_class = CLS_LUI;
      OP_JAL:  o_class = CLS_JAL;
      OP_JALR: o_class = CLS_JALR;
      OP_HALT: o_class = CLS_HALT;
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multi-cycle main control unit: sequences each instruction through
// fetch/decode/execute/memory/write-back with ready-handshaked memories,
// a wait timeout trap and a retired-instruction counter.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_FETCH   | request instruction; load IR when imem_ready
// S_DECODE  | latch instruction class, pick halt/trap/execute
// S_EXEC    | ALU controls; branches resolve and retire here
// S_MEM     | hold data strobe until dmem_ready; SW retires here
// S_WB      | register write and PC update; retire
// S_HALTED  | halt executed; absorbing until reset
// S_TRAPPED | illegal opcode or memory timeout; absorbing until reset
module multicycle_controller
  import riscv_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 15,
  parameter int RETIRE_W    = 32
) (
  input logic clk,
  input logic reset,
  multicycle_controller_if.master bus
);

  localparam int CNT_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

  state_t              r_state, w_state_nxt;
  iclass_t             r_class, w_dec_class;
  logic                w_dec_illegal;
  logic [CNT_W-1:0]    r_wait_cnt;
  logic [RETIRE_W-1:0] r_retired;
  logic                r_halt, r_trap;
  logic [1:0]          r_trap_cause;

  logic       w_ready, w_timeout, w_retire, w_halt_set, w_trap_set;
  logic [1:0] w_trap_cause;
  logic       w_imem_req, w_irwrite, w_pcwrite, w_alusrc;
  logic       w_memread, w_memwrite, w_regwrite;
  logic [1:0] w_pcsrc, w_aluop, w_wbsel;

  ctrl_opcode_decode u_decode (
    .i_opcode  (bus.Opcode),
    .o_class   (w_dec_class),
    .o_illegal (w_dec_illegal)
  );

  assign w_ready   = (r_state == S_FETCH) ? bus.imem_ready : bus.dmem_ready;
  assign w_timeout = (r_wait_cnt == TIMEOUT_CNT) && !w_ready;

  // Next-state and datapath strobe decode from registered state and class.
  always_comb begin
    w_state_nxt  = r_state;
    w_retire     = 1'b0;
    w_halt_set   = 1'b0;
    w_trap_set   = 1'b0;
    w_trap_cause = TC_NONE;
    w_imem_req   = 1'b0;
    w_irwrite    = 1'b0;
    w_pcwrite    = 1'b0;
    w_pcsrc      = PCSRC_PLUS4;
    w_alusrc     = 1'b0;
    w_aluop      = ALUOP_ADD;
    w_memread    = 1'b0;
    w_memwrite   = 1'b0;
    w_wbsel      = WB_ALU;
    w_regwrite   = 1'b0;
    case (r_state)
      S_FETCH: begin
        w_imem_req = 1'b1;
        if (bus.imem_ready) begin
          w_irwrite   = 1'b1;
          w_state_nxt = S_DECODE;
        end else if (w_timeout) begin
          w_trap_set   = 1'b1;
          w_trap_cause = TC_IMEM;
          w_state_nxt  = S_TRAPPED;
        end
      end
      S_DECODE: begin
        if (w_dec_illegal) begin
          w_trap_set   = 1'b1;
          w_trap_cause = TC_ILLEGAL;
          w_state_nxt  = S_TRAPPED;
        end else if (w_dec_class == CLS_HALT) begin
          w_halt_set  = 1'b1;
          w_state_nxt = S_HALTED;
        end else begin
          w_state_nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        w_state_nxt = S_WB;
        case (r_class)
          CLS_R:  w_aluop = ALUOP_FUNCT;
          CLS_I: begin
            w_alusrc = 1'b1;
            w_aluop  = ALUOP_FUNCT;
          end
          CLS_LW, CLS_SW: begin
            w_alusrc    = 1'b1;
            w_state_nxt = S_MEM;
          end
          CLS_BR: begin
            w_aluop     = ALUOP_BR;
            w_pcwrite   = 1'b1;
            w_pcsrc     = bus.BranchTaken ? PCSRC_IMM : PCSRC_PLUS4;
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end
          CLS_LUI: begin
            w_alusrc = 1'b1;
            w_aluop  = ALUOP_LUI;
          end
          CLS_JALR: w_alusrc = 1'b1;
          default: ;
        endcase
      end
      S_MEM: begin
        w_alusrc   = 1'b1;
        w_memread  = (r_class == CLS_LW);
        w_memwrite = (r_class == CLS_SW);
        if (bus.dmem_ready) begin
          if (r_class == CLS_SW) begin
            w_pcwrite   = 1'b1;
            w_retire    = 1'b1;
            w_state_nxt = S_FETCH;
          end else begin
            w_state_nxt = S_WB;
          end
        end else if (w_timeout) begin
          w_trap_set   = 1'b1;
          w_trap_cause = TC_DMEM;
          w_state_nxt  = S_TRAPPED;
        end
      end
      S_WB: begin
        w_regwrite  = 1'b1;
        w_pcwrite   = 1'b1;
        w_retire    = 1'b1;
        w_state_nxt = S_FETCH;
        case (r_class)
          CLS_LW:  w_wbsel = WB_MEM;
          CLS_JAL: begin
            w_wbsel = WB_PC4;
            w_pcsrc = PCSRC_IMM;
          end
          CLS_JALR: begin
            w_wbsel  = WB_PC4;
            w_pcsrc  = PCSRC_ALU;
            w_alusrc = 1'b1;
          end
          default: ;
        endcase
      end
      S_HALTED, S_TRAPPED: ;
      default: w_state_nxt = S_FETCH;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_FETCH;
    else        r_state <= w_state_nxt;
  end

  // Instruction class is captured once, in DECODE, and held for the rest of the instruction.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   r_class <= CLS_NONE;
    else if (r_state == S_DECODE) r_class <= w_dec_class;
  end

  // Wait counter: cleared on every state change, counts while stalled in FETCH or MEM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                         r_wait_cnt <= '0;
    else if (w_state_nxt != r_state)                    r_wait_cnt <= '0;
    else if ((r_state == S_FETCH) || (r_state == S_MEM)) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
  end

  // Retired counter, wrapping naturally at its width.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)        r_retired <= '0;
    else if (w_retire) r_retired <= r_retired + RETIRE_W'(1);
  end

  // Sticky halt/trap status with the trap cause.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_halt       <= 1'b0;
      r_trap       <= 1'b0;
      r_trap_cause <= TC_NONE;
    end else begin
      if (w_halt_set) r_halt <= 1'b1;
      if (w_trap_set) begin
        r_trap       <= 1'b1;
        r_trap_cause <= w_trap_cause;
      end
    end
  end

  // Strobes are gated by reset so they drop the moment reset asserts, even
  // though the state register would otherwise show FETCH.
  assign bus.imem_req  = w_imem_req & reset;
  assign bus.IRWrite   = w_irwrite & reset;
  assign bus.PCWrite   = w_pcwrite & reset;
  assign bus.PCSrc     = w_pcsrc & {2{reset}};
  assign bus.ALUSrc    = w_alusrc & reset;
  assign bus.ALUOp     = w_aluop & {2{reset}};
  assign bus.MemRead   = w_memread & reset;
  assign bus.MemWrite  = w_memwrite & reset;
  assign bus.WBSel     = w_wbsel & {2{reset}};
  assign bus.RegWrite  = w_regwrite & reset;
  assign bus.Halt      = r_halt;
  assign bus.Trap      = r_trap;
  assign bus.TrapCause = r_trap_cause;
  assign bus.retired   = r_retired;

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller with a cycle-timeline reference model.
module tb_multicycle_controller;

  localparam int TMO = 15;
  localparam int RW  = 4;

  localparam logic [6:0] K_R    = 7'b0110011;
  localparam logic [6:0] K_LW   = 7'b0000011;
  localparam logic [6:0] K_SW   = 7'b0100011;
  localparam logic [6:0] K_BR   = 7'b1100011;
  localparam logic [6:0] K_I    = 7'b0010011;
  localparam logic [6:0] K_LUI  = 7'b0110111;
  localparam logic [6:0] K_JAL  = 7'b1101111;
  localparam logic [6:0] K_JALR = 7'b1100111;
  localparam logic [6:0] K_HALT = 7'b0000001;

  logic [6:0] legal_ops [8] = '{K_R, K_LW, K_SW, K_BR, K_I, K_LUI, K_JAL, K_JALR};

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;
  int   exp_retired = 0;

  multicycle_controller_if #(.RETIRE_W(RW)) ifc ();

  multicycle_controller #(.MEM_TIMEOUT(TMO), .RETIRE_W(RW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  // {imem_req, IRWrite, PCWrite, PCSrc, ALUSrc, ALUOp, MemRead, MemWrite, WBSel, RegWrite}
  function automatic logic [12:0] get_obs();
    return {ifc.imem_req, ifc.IRWrite, ifc.PCWrite, ifc.PCSrc, ifc.ALUSrc, ifc.ALUOp,
            ifc.MemRead, ifc.MemWrite, ifc.WBSel, ifc.RegWrite};
  endfunction

  function automatic int model_len(input logic [6:0] op, input int iw, input int dw);
    if (op == K_BR) return iw + 3;
    if (op == K_SW) return iw + 4 + dw;
    if (op == K_LW) return iw + 5 + dw;
    return iw + 4;
  endfunction

  // Expected strobes for cycle cyc of an instruction whose fetch waits iw cycles
  // and whose data access waits dw cycles.
  function automatic logic [12:0] model_out(input logic [6:0] op, input int cyc,
                                            input int iw, input int dw, input logic bt);
    logic req, irw, pcw, als, mr, mw, rw;
    logic [1:0] pcs, aop, wbs;
    int t;
    req = 0; irw = 0; pcw = 0; als = 0; mr = 0; mw = 0; rw = 0;
    pcs = 0; aop = 0; wbs = 0;
    t = cyc - iw;
    if (t < 0) req = 1;
    else if (t == 0) begin req = 1; irw = 1; end
    else if (t == 1) ;
    else if (t == 2) begin
      if (op == K_R)    aop = 2'b10;
      if (op == K_I)    begin als = 1; aop = 2'b10; end
      if (op == K_LW || op == K_SW || op == K_JALR) als = 1;
      if (op == K_BR)   begin aop = 2'b01; pcw = 1; pcs = bt ? 2'b01 : 2'b00; end
      if (op == K_LUI)  begin als = 1; aop = 2'b11; end
    end else if ((op == K_LW || op == K_SW) && t <= 3 + dw) begin
      als = 1;
      mr  = (op == K_LW);
      mw  = (op == K_SW);
      if (op == K_SW && t == 3 + dw) pcw = 1;
    end else begin
      rw = 1; pcw = 1;
      if (op == K_LW)   wbs = 2'b01;
      if (op == K_JAL)  begin wbs = 2'b10; pcs = 2'b01; end
      if (op == K_JALR) begin wbs = 2'b10; pcs = 2'b10; als = 1; end
    end
    return {req, irw, pcw, pcs, als, aop, mr, mw, wbs, rw};
  endfunction

  // Reset for two edges; release just after a rising edge so cycle 0 of the
  // next instruction starts immediately.
  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    ifc.imem_ready = 1'b0; ifc.dmem_ready = 1'b0; ifc.BranchTaken = 1'b0; ifc.Opcode = 7'h00;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    exp_retired = 0;
  endtask

  // Run one instruction cycle by cycle; opcode is valid only in DECODE.
  task automatic run_instr(input logic [6:0] op, input int iw, input int dw, input logic bt);
    logic [12:0] obs, ev;
    int len;
    len = model_len(op, iw, dw);
    for (int c = 0; c < len; c++) begin
      ifc.imem_ready  = (c == iw);
      ifc.dmem_ready  = (c == iw + 3 + dw);
      ifc.Opcode      = (c == iw + 1) ? op : 7'($urandom);
      ifc.BranchTaken = bt;
      @(negedge clk);
      obs = get_obs();
      ev  = model_out(op, c, iw, dw, bt);
      checks++;
      if (obs !== ev) begin
        errors++;
        $display("FAIL strobes op=%b iw=%0d dw=%0d cyc=%0d got=%b exp=%b", op, iw, dw, c, obs, ev);
      end
      @(posedge clk); #1;
    end
    exp_retired = (exp_retired + 1) % (1 << RW);
    checks++;
    if (ifc.retired !== RW'(exp_retired)) begin
      errors++;
      $display("FAIL retired op=%b got=%0d exp=%0d", op, ifc.retired, exp_retired);
    end
    checks++;
    if ({ifc.Halt, ifc.Trap, ifc.TrapCause} !== 4'b0000) begin
      errors++;
      $display("FAIL status op=%b got=%b exp=0000", op, {ifc.Halt, ifc.Trap, ifc.TrapCause});
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    ifc.imem_ready = 1'b0; ifc.dmem_ready = 1'b0; ifc.BranchTaken = 1'b0; ifc.Opcode = 7'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({get_obs(), ifc.Halt, ifc.Trap, ifc.TrapCause, ifc.retired} !== '0) begin
      errors++;
      $display("FAIL reset_values got=%b retired=%0d exp=all zero",
               {get_obs(), ifc.Halt, ifc.Trap, ifc.TrapCause}, ifc.retired);
    end
    @(posedge clk); #1 reset = 1'b1;
    #1;
    checks++;
    if (ifc.imem_req !== 1'b1) begin
      errors++;
      $display("FAIL first_fetch imem_req got=%b exp=1", ifc.imem_req);
    end
    #(-1+1);
    exp_retired = 0;
  endtask

  // Trap on a stalled memory: side 0 = instruction memory, 1 = data memory (LW).
  task automatic test_timeout(input bit dside);
    int first;
    do_reset();
    first = dside ? 3 : 0;
    for (int c = 0; c < first + TMO + 1; c++) begin
      ifc.imem_ready = dside && (c == 0);
      ifc.dmem_ready = 1'b0;
      ifc.Opcode     = (c == 1) ? K_LW : 7'($urandom);
      @(negedge clk);
      if (c >= first) begin
        checks++;
        if ((dside ? ifc.MemRead : ifc.imem_req) !== 1'b1 || ifc.Trap !== 1'b0) begin
          errors++;
          $display("FAIL timeout_wait side=%0d cyc=%0d req=%b trap=%b exp req=1 trap=0",
                   dside, c, dside ? ifc.MemRead : ifc.imem_req, ifc.Trap);
        end
      end
      @(posedge clk); #1;
    end
    ifc.imem_ready = 1'b1; ifc.dmem_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifc.Trap, ifc.TrapCause, get_obs(), ifc.retired} !== {1'b1, dside ? 2'b11 : 2'b10, 13'd0, 4'd0}) begin
      errors++;
      $display("FAIL timeout_trap side=%0d trap=%b cause=%b strobes=%b retired=%0d exp trap=1 cause=%b strobes=0 retired=0",
               dside, ifc.Trap, ifc.TrapCause, get_obs(), ifc.retired, dside ? 2'b11 : 2'b10);
    end
  endtask

  task automatic test_wait_edges();
    do_reset();
    run_instr(K_R, TMO, 0, 1'b0);
    run_instr(K_LW, 0, TMO, 1'b0);
    run_instr(K_SW, TMO, TMO, 1'b0);
  endtask

  task automatic test_illegal_halt();
    do_reset();
    ifc.imem_ready = 1'b1; ifc.Opcode = 7'h00;
    @(posedge clk); #1;
    ifc.imem_ready = 1'b0; ifc.Opcode = 7'b1111111;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifc.Trap, ifc.TrapCause, ifc.Halt, get_obs()} !== {1'b1, 2'b01, 1'b0, 13'd0}) begin
      errors++;
      $display("FAIL illegal trap=%b cause=%b halt=%b strobes=%b exp 1 01 0 0",
               ifc.Trap, ifc.TrapCause, ifc.Halt, get_obs());
    end
    do_reset();
    run_instr(K_I, 1, 0, 1'b0);
    ifc.imem_ready = 1'b1; ifc.Opcode = 7'h00;
    @(posedge clk); #1;
    ifc.imem_ready = 1'b1; ifc.Opcode = K_HALT;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ifc.Halt, ifc.Trap, get_obs()} !== {1'b1, 1'b0, 13'd0} || ifc.retired !== RW'(exp_retired)) begin
      errors++;
      $display("FAIL halt halt=%b trap=%b strobes=%b retired=%0d exp 1 0 0 retired=%0d",
               ifc.Halt, ifc.Trap, get_obs(), ifc.retired, exp_retired);
    end
  endtask

  task automatic test_reset_mid_mem();
    do_reset();
    run_instr(K_R, 0, 0, 1'b0);
    for (int c = 0; c < 4; c++) begin
      ifc.imem_ready = (c == 0); ifc.dmem_ready = 1'b0;
      ifc.Opcode = (c == 1) ? K_LW : 7'h00;
      if (c < 3) begin @(posedge clk); #1; end
    end
    @(negedge clk);
    checks++;
    if (ifc.MemRead !== 1'b1) begin
      errors++;
      $display("FAIL mid_mem MemRead got=%b exp=1", ifc.MemRead);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if (get_obs() !== 13'd0 || ifc.retired !== '0) begin
      errors++;
      $display("FAIL async_reset strobes=%b retired=%0d exp 0 0", get_obs(), ifc.retired);
    end
    @(posedge clk); #1 reset = 1'b1;
    exp_retired = 0;
    run_instr(K_JAL, 0, 0, 1'b0);
  endtask

  task automatic test_random(input int n);
    for (int k = 0; k < n; k++)
      run_instr(legal_ops[$urandom_range(7)], ($urandom_range(3) == 0) ? $urandom_range(TMO) : $urandom_range(2),
                ($urandom_range(3) == 0) ? $urandom_range(TMO) : $urandom_range(2), 1'($urandom));
  endtask

  task automatic test_wrap();
    do_reset();
    test_random(16);
    checks++;
    if (ifc.retired !== 4'd0) begin
      errors++;
      $display("FAIL retired_wrap got=%0d exp=0", ifc.retired);
    end
  endtask

  initial begin
    test_reset();
    run_instr(K_R, 0, 0, 1'b0);
    run_instr(K_LW, 0, 3, 1'b0);
    run_instr(K_BR, 0, 0, 1'b1);
    run_instr(K_BR, 0, 0, 1'b0);
    run_instr(K_JALR, 0, 0, 1'b0);
    run_instr(K_SW, 2, 1, 1'b0);
    run_instr(K_LUI, 1, 0, 1'b0);
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_wait_edges();
    test_illegal_halt();
    test_reset_mid_mem();
    do_reset();
    test_random(40);
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
